// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game-tick sequencer:
//   - direction encodings (dir_e)
//   - sequencer FSM state enum (state_e)
//   - default playfield geometry and body-store depth
//   - segment record {x, y} as stored in the segment RAM (seg_t)
//   - is_opposite(): true when two directions are direct reversals
// Optional feature macro used by snake_step_ctrl: SNAKE_SELF_COLLIDE_EN.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W_DEF  = 64;
    localparam int GRID_H_DEF  = 48;
    localparam int MAX_LEN_DEF = 128;
    localparam int XW_DEF      = 6;
    localparam int YW_DEF      = 6;

    // Reversal pairs differ in both bits: 11/00 and 10/01.
    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_INIT  = 4'd1,
        ST_WAIT  = 4'd2,
        ST_SCAN  = 4'd3,
        ST_SHIFT = 4'd4,
        ST_HEAD  = 4'd5,
        ST_FOOD  = 4'd6,
        ST_FCHK  = 4'd7,
        ST_OVER  = 4'd8
    } state_e;

    typedef struct packed {
        logic [XW_DEF-1:0] x;
        logic [YW_DEF-1:0] y;
    } seg_t;

    function automatic logic is_opposite(input dir_e a, input dir_e b);
        return ((2'(a) ^ 2'(b)) == 2'b11);
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// -----------------------------------------------------------------------------
// snake_dir_filter
// Holds the pending and current movement directions and drops reversal
// requests (a snake may never turn straight back into its own neck).
//   iCLK, iRST_N : clock, asynchronous active-low reset (both dirs -> LEFT)
//   iInit        : game (re)start, forces both directions to LEFT
//   iTake        : accepted game tick; pending becomes current
//   iDir         : requested direction
//   iDirValid    : iDir qualifier, accepted in any sequencer state
//   oDir_Next    : direction the next accepted tick will move in (pending)
// -----------------------------------------------------------------------------
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iInit,
    input  logic iTake,
    input  dir_e iDir,
    input  logic iDirValid,
    output dir_e oDir_Next
);

    dir_e cur_q, cur_d;
    dir_e pend_q, pend_d;
    dir_e cmp_ref;
    logic accept;

    always_comb begin
        // On the tick cycle the pending value is about to become current, so
        // a same-cycle request is judged against it; otherwise two quick
        // requests could reverse the snake across consecutive ticks.
        cmp_ref = iTake ? pend_q : cur_q;
        accept  = iDirValid && !is_opposite(iDir, cmp_ref);
        cur_d   = cur_q;
        pend_d  = pend_q;
        if (iTake) begin
            cur_d = pend_q;
        end
        if (accept) begin
            pend_d = iDir;
        end
        if (iInit) begin
            cur_d  = DIR_LEFT;
            pend_d = DIR_LEFT;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cur_q  <= DIR_LEFT;
            pend_q <= DIR_LEFT;
        end else begin
            cur_q  <= cur_d;
            pend_q <= pend_d;
        end
    end

    assign oDir_Next = pend_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl
// Game-tick sequencer for the snake body store. Owns the single-port segment
// RAM (address 0 = head) and performs one update per accepted game tick:
// step head with wrap, optional self-collision scan, body shift, head write,
// growth, and the food respawn handshake with the LFSR food generator.
//
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iStart                start/restart pulse (honoured in IDLE and OVER only)
//   iTick                 game tick pulse (honoured in WAIT only, not queued)
//   iDir, iDirValid       direction request (11 up, 00 down, 10 left, 01 right)
//   oRam_Addr/WData/We    segment RAM port, data = {x, y}
//   iRam_RData            RAM read data, one cycle after the address
//   oFood_Req, iFood_Ack  food request / one-cycle candidate valid
//   iFood_X, iFood_Y      food candidate from the generator
//   oFood_X/Y, oFood_Valid placed food
//   oHead_X/Y, oLength    current head and length
//   oBusy                 update in progress; RAM stable only while 0
//   oGameOver             game ended by self-collision
//
// Build option: define SNAKE_SELF_COLLIDE_EN to include the self-collision
// scan (SCAN state). Without it the snake passes through itself.
// -----------------------------------------------------------------------------
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int LW       = 8,
    parameter int INIT_LEN = 4
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iStart,
    input  logic            iTick,
    input  logic [1:0]      iDir,
    input  logic            iDirValid,
    output logic [LW-1:0]   oRam_Addr,
    output logic [XW+YW-1:0] oRam_WData,
    output logic            oRam_We,
    input  logic [XW+YW-1:0] iRam_RData,
    output logic            oFood_Req,
    input  logic            iFood_Ack,
    input  logic [XW-1:0]   iFood_X,
    input  logic [YW-1:0]   iFood_Y,
    output logic [XW-1:0]   oFood_X,
    output logic [YW-1:0]   oFood_Y,
    output logic            oFood_Valid,
    output logic [XW-1:0]   oHead_X,
    output logic [YW-1:0]   oHead_Y,
    output logic [LW-1:0]   oLength,
    output logic            oBusy,
    output logic            oGameOver
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   end_q, end_d;
    logic [XW-1:0]   head_x_q, head_x_d, new_x_q, new_x_d;
    logic [YW-1:0]   head_y_q, head_y_d, new_y_q, new_y_d;
    logic [XW-1:0]   cand_x_q, cand_x_d, food_x_q, food_x_d;
    logic [YW-1:0]   cand_y_q, cand_y_d, food_y_q, food_y_d;
    logic            grow_q, grow_d;
    logic            ate_q, ate_d;
    logic            shift_ph_q, shift_ph_d;
    logic            rd_v_q, rd_v_d;
    logic            rd_last_q, rd_last_d;
    logic            food_valid_q, food_valid_d;
    logic            over_q, over_d;

    logic [XW-1:0]   step_x;
    logic [YW-1:0]   step_y;
    logic            step_food, step_grow;
    logic [LW-1:0]   step_last;
    dir_e            dir_next;
    logic            dir_take, dir_init;
    logic [XW+YW-1:0] scan_ref;
    logic            scan_hit, scan_done, food_in_grid;
    logic [LW-1:0]   ram_addr;
    logic [XW+YW-1:0] ram_wdata;
    logic            ram_we;

    snake_dir_filter u_dir (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iInit     (dir_init),
        .iTake     (dir_take),
        .iDir      (dir_e'(iDir)),
        .iDirValid (iDirValid),
        .oDir_Next (dir_next)
    );

    // Candidate head for the next tick, with playfield wrap, plus the
    // eat/grow decision and the last body index that must be checked/moved.
    always_comb begin
        step_x = head_x_q;
        step_y = head_y_q;
        case (dir_next)
            DIR_LEFT:  step_x = (head_x_q == '0)    ? X_MAX : head_x_q - XW'(1);
            DIR_RIGHT: step_x = (head_x_q == X_MAX) ? '0    : head_x_q + XW'(1);
            DIR_UP:    step_y = (head_y_q == '0)    ? Y_MAX : head_y_q - YW'(1);
            default:   step_y = (head_y_q == Y_MAX) ? '0    : head_y_q + YW'(1);
        endcase
        step_food = food_valid_q && (step_x == food_x_q) && (step_y == food_y_q);
        // At full length food is still consumed (respawned) but no growth.
        step_grow = step_food && (len_q < LW'(MAX_LEN));
        // Without growth the tail cell vacates this tick, so it is neither
        // a collision nor moved.
        step_last = step_grow ? (len_q - LW'(1)) : (len_q - LW'(2));
    end

    // Pipelined scan compare: rd_v_q marks that iRam_RData holds the word
    // addressed last cycle; rd_last_q marks it as the final one.
    always_comb begin
        scan_ref     = (state_q == ST_FCHK) ? {cand_x_q, cand_y_q} : {new_x_q, new_y_q};
        scan_hit     = rd_v_q && (iRam_RData == scan_ref);
        scan_done    = rd_v_q && rd_last_q;
        food_in_grid = (int'(iFood_X) < GRID_W) && (int'(iFood_Y) < GRID_H);
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        end_d        = end_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        grow_d       = grow_q;
        ate_d        = ate_q;
        shift_ph_d   = shift_ph_q;
        over_d       = over_q;
        rd_v_d       = 1'b0;
        rd_last_d    = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_we       = 1'b0;
        dir_take     = 1'b0;
        dir_init     = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (iStart) begin
                    state_d      = ST_INIT;
                    dir_init     = 1'b1;
                    idx_d        = '0;
                    head_x_d     = X_MID;
                    head_y_d     = Y_MID;
                    len_d        = LW'(INIT_LEN);
                    over_d       = 1'b0;
                    food_valid_d = 1'b0;
                    food_x_d     = '0;
                    food_y_d     = '0;
                end
            end

            ST_INIT: begin
                // Horizontal snake facing left: head at the centre, body to the right.
                ram_addr  = idx_q;
                ram_we    = 1'b1;
                ram_wdata = {X_MID + XW'(idx_q), Y_MID};
                if (idx_q == LW'(INIT_LEN - 1)) begin
                    state_d = ST_FOOD;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end

            ST_WAIT: begin
                if (iTick) begin
                    dir_take = 1'b1;
                    new_x_d  = step_x;
                    new_y_d  = step_y;
                    grow_d   = step_grow;
                    ate_d    = step_food;
                    end_d    = step_last;
`ifdef SNAKE_SELF_COLLIDE_EN
                    state_d    = ST_SCAN;
                    idx_d      = '0;
`else
                    state_d    = ST_SHIFT;
                    idx_d      = step_last + LW'(1);
                    shift_ph_d = 1'b0;
`endif
                end
            end

`ifdef SNAKE_SELF_COLLIDE_EN
            ST_SCAN: begin
                if (idx_q <= end_q) begin
                    ram_addr  = idx_q;
                    rd_v_d    = 1'b1;
                    rd_last_d = (idx_q == end_q);
                    idx_d     = idx_q + LW'(1);
                end
                if (scan_hit) begin
                    state_d = ST_OVER;
                    over_d  = 1'b1;
                end else if (scan_done) begin
                    state_d    = ST_SHIFT;
                    idx_d      = end_q + LW'(1);
                    shift_ph_d = 1'b0;
                end
            end
`endif

            ST_SHIFT: begin
                // Phase 0 reads segment idx-1, phase 1 writes it to idx.
                if (!shift_ph_q) begin
                    ram_addr   = idx_q - LW'(1);
                    shift_ph_d = 1'b1;
                end else begin
                    ram_addr   = idx_q;
                    ram_we     = 1'b1;
                    ram_wdata  = iRam_RData;
                    shift_ph_d = 1'b0;
                    if (idx_q == LW'(1)) begin
                        state_d = ST_HEAD;
                    end else begin
                        idx_d = idx_q - LW'(1);
                    end
                end
            end

            ST_HEAD: begin
                ram_addr  = '0;
                ram_we    = 1'b1;
                ram_wdata = {new_x_q, new_y_q};
                head_x_d  = new_x_q;
                head_y_d  = new_y_q;
                if (grow_q) begin
                    len_d = len_q + LW'(1);
                end
                if (ate_q) begin
                    state_d      = ST_FOOD;
                    food_valid_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_FOOD: begin
                food_valid_d = 1'b0;
                if (iFood_Ack && food_in_grid) begin
                    cand_x_d = iFood_X;
                    cand_y_d = iFood_Y;
                    idx_d    = '0;
                    end_d    = len_q - LW'(1);
                    state_d  = ST_FCHK;
                end
            end

            ST_FCHK: begin
                if (idx_q <= end_q) begin
                    ram_addr  = idx_q;
                    rd_v_d    = 1'b1;
                    rd_last_d = (idx_q == end_q);
                    idx_d     = idx_q + LW'(1);
                end
                if (scan_hit) begin
                    state_d = ST_FOOD;
                end else if (scan_done) begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            end_q        <= '0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            grow_q       <= 1'b0;
            ate_q        <= 1'b0;
            shift_ph_q   <= 1'b0;
            rd_v_q       <= 1'b0;
            rd_last_q    <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            end_q        <= end_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            grow_q       <= grow_d;
            ate_q        <= ate_d;
            shift_ph_q   <= shift_ph_d;
            rd_v_q       <= rd_v_d;
            rd_last_q    <= rd_last_d;
            over_q       <= over_d;
        end
    end

    assign oRam_Addr   = ram_addr;
    assign oRam_WData  = ram_wdata;
    assign oRam_We     = ram_we;
    assign oFood_Req   = (state_q == ST_FOOD);
    assign oFood_X     = food_x_q;
    assign oFood_Y     = food_y_q;
    assign oFood_Valid = food_valid_q;
    assign oHead_X     = head_x_q;
    assign oHead_Y     = head_y_q;
    assign oLength     = len_q;
    assign oBusy       = !((state_q == ST_IDLE) || (state_q == ST_WAIT) || (state_q == ST_OVER));
    assign oGameOver   = over_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_step_ctrl
// Directed bench for snake_step_ctrl with a behavioural segment RAM.
// Handshake: iFood_Ack is a one-cycle pulse while oFood_Req is high; oBusy
// low means the sequencer is parked (IDLE, WAIT or OVER).
// -----------------------------------------------------------------------------
module tb_snake_step_ctrl;
    import snake_pkg::*;

    localparam int LW = 8;
    localparam int XW = 6;
    localparam int YW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start, tick, dir_valid, food_ack;
    logic [1:0]    dir;
    logic [XW-1:0] food_x_in;
    logic [YW-1:0] food_y_in;
    logic [LW-1:0] ram_addr;
    logic [XW+YW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, food_req, food_valid, busy, game_over;
    logic [XW-1:0] food_x, head_x;
    logic [YW-1:0] food_y, head_y;
    logic [LW-1:0] length;

    logic [XW+YW-1:0] mem [0:127];
    logic [XW+YW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       dv;
        logic [1:0] d;
        int         hx;
        int         hy;
        int         len;
    } vec_t;
    vec_t vecs [6];

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    snake_step_ctrl dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iStart      (start),
        .iTick       (tick),
        .iDir        (dir),
        .iDirValid   (dir_valid),
        .oRam_Addr   (ram_addr),
        .oRam_WData  (ram_wdata),
        .oRam_We     (ram_we),
        .iRam_RData  (ram_rdata),
        .oFood_Req   (food_req),
        .iFood_Ack   (food_ack),
        .iFood_X     (food_x_in),
        .iFood_Y     (food_y_in),
        .oFood_X     (food_x),
        .oFood_Y     (food_y),
        .oFood_Valid (food_valid),
        .oHead_X     (head_x),
        .oHead_Y     (head_y),
        .oLength     (length),
        .oBusy       (busy),
        .oGameOver   (game_over)
    );

    // Segment RAM: synchronous write, synchronous read (read-before-write).
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[6:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[6:0]];
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [XW+YW-1:0] seg(input int x, input int y);
        seg_t s;
        s.x = XW'(x);
        s.y = YW'(y);
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ram_addr"}, ram_addr, 0);
        check({tag, " ram_wdata"}, ram_wdata, 0);
        check({tag, " ram_we"}, ram_we, 0);
        check({tag, " food_req"}, food_req, 0);
        check({tag, " food_x"}, food_x, 0);
        check({tag, " food_y"}, food_y, 0);
        check({tag, " food_valid"}, food_valid, 0);
        check({tag, " head_x"}, head_x, 0);
        check({tag, " head_y"}, head_y, 0);
        check({tag, " length"}, length, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " game_over"}, game_over, 0);
    endtask

    task automatic check_head(input string tag, input int x, input int y);
        check({tag, " head_x"}, head_x, x);
        check({tag, " head_y"}, head_y, y);
    endtask

    // Compares RAM addresses 0..n-1 against the front of exp_q.
    task automatic check_mem(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s mem[%0d]", tag, i), mem[i], exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!food_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " food_req"}, food_req, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        dir = d;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic send_food(input int x, input int y);
        @(negedge clk);
        food_ack  = 1'b1;
        food_x_in = XW'(x);
        food_y_in = YW'(y);
        @(negedge clk);
        food_ack = 1'b0;
    endtask

    task automatic step(input string tag);
        pulse_tick();
        wait_idle(tag);
    endtask

    task automatic move(input logic [1:0] d, input int n);
        set_dir(d);
        for (int i = 0; i < n; i++) step($sformatf("move%0d", i));
    endtask

    // Starts a game and checks the initial body and state.
    task automatic new_game(input string tag);
        pulse_start();
        wait_req(tag);
        check({tag, " length"}, length, 4);
        check_head(tag, 32, 24);
        check({tag, " game_over"}, game_over, 0);
        check({tag, " busy"}, busy, 1);
        for (int k = 0; k < 4; k++) exp_q.push_back(seg(32 + k, 24));
        check_mem(tag, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        start = 0; tick = 0; dir = 2'b00; dir_valid = 0;
        food_ack = 0; food_x_in = '0; food_y_in = '0;

        // Expected positions after each tick, starting from head (31,24),
        // length 5, moving left.
        vecs[0] = '{dv: 1'b0, d: 2'b00, hx: 30, hy: 24, len: 5};
        vecs[1] = '{dv: 1'b1, d: 2'b01, hx: 29, hy: 24, len: 5}; // reversal dropped
        vecs[2] = '{dv: 1'b1, d: 2'b11, hx: 29, hy: 23, len: 5}; // up
        vecs[3] = '{dv: 1'b1, d: 2'b00, hx: 29, hy: 22, len: 5}; // reversal dropped
        vecs[4] = '{dv: 1'b1, d: 2'b01, hx: 30, hy: 22, len: 5}; // right
        vecs[5] = '{dv: 1'b1, d: 2'b00, hx: 30, hy: 23, len: 5}; // down

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        new_game("start");
        send_food(31, 24);
        wait_idle("place1");
        check("place1 food_valid", food_valid, 1);
        check("place1 food_x", food_x, 31);
        check("place1 food_y", food_y, 24);

        // iStart in WAIT is ignored
        pulse_start();
        check("start_in_wait busy", busy, 0);
        check("start_in_wait length", length, 4);

        // Eat: head steps onto food, grows, tail kept at addr 4
        pulse_tick();
        wait_req("eat");
        check("eat length", length, 5);
        check_head("eat", 31, 24);
        check("eat food_valid", food_valid, 0);
        for (int k = 0; k < 5; k++) exp_q.push_back(seg(31 + k, 24));
        check_mem("eat", 5);

        pulse_tick(); // ignored outside WAIT
        send_food(33, 24); // on the body
        check("ack req_drop", food_req, 0);
        wait_req("rerequest");
        check("rerequest food_valid", food_valid, 0);
        send_food(5, 50); // off the grid
        check("offgrid food_req", food_req, 1);
        send_food(5, 5);
        wait_idle("place2");
        check("place2 food_valid", food_valid, 1);
        check("place2 food_x", food_x, 5);
        check("place2 food_y", food_y, 5);
        check_head("tick_in_food", 31, 24);
        check("tick_in_food length", length, 5);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].dv) set_dir(vecs[i].d);
            step($sformatf("vec%0d", i));
            check_head($sformatf("vec%0d", i), vecs[i].hx, vecs[i].hy);
            check($sformatf("vec%0d length", i), length, vecs[i].len);
        end

        // Turning left now lands on segment 3 (the tail at 4 vacates).
        set_dir(2'b10);
        step("curl");
`ifdef SNAKE_SELF_COLLIDE_EN
        check("curl game_over", game_over, 1);
        check_head("curl", 30, 23);
        check("curl length", length, 5);
        pulse_tick();
        repeat (3) @(negedge clk);
        check_head("over_tick", 30, 23);
        check("over_tick busy", busy, 0);
        check("over_tick game_over", game_over, 1);
        new_game("restart");
        send_food(5, 5);
        wait_idle("restart place");
`else
        check("curl game_over", game_over, 0);
        check_head("curl", 29, 23);
        check("curl length", length, 5);
`endif

        // Reset in the middle of the body shift
        pulse_tick();
        repeat (6) @(negedge clk);
        check("midshift busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midshift_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        new_game("after_reset");
        send_food(5, 5);
        wait_idle("after_reset place");
        check("after_reset food_valid", food_valid, 1);

        // Wrap at all four edges
        move(2'b11, 14);
        check_head("to_y10", 32, 10);
        move(2'b10, 32);
        check_head("to_x0", 0, 10);
        move(2'b10, 1);
        check_head("wrap_left", 63, 10);
        exp_q.push_back(seg(63, 10));
        exp_q.push_back(seg(0, 10));
        exp_q.push_back(seg(1, 10));
        exp_q.push_back(seg(2, 10));
        check_mem("wrap_left", 4);
        move(2'b11, 11);
        check_head("wrap_up", 63, 47);
        move(2'b01, 1);
        check_head("wrap_right", 0, 47);
        move(2'b00, 1);
        check_head("wrap_down", 0, 0);
        check("final length", length, 4);
        check("final game_over", game_over, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Game-tick sequencer for the snake body store: owns the single-port segment RAM and runs one update per game tick.
- Update steps: take direction, compute new head with wrap, self-collision scan, body shift, head write, growth, food-respawn handshake with the LFSR food generator.
- The VGA renderer reads the segment RAM through its own read port and treats contents as stable only while oBusy=0.

Parameters:
- GRID_W, 64: playfield columns.
- GRID_H, 48: playfield rows.
- XW, 6: x coordinate width.
- YW, 6: y coordinate width.
- MAX_LEN, 128: segment RAM depth and maximum length.
- LW, 8: length/address width; must hold MAX_LEN.
- INIT_LEN, 4: segments written at game start.

Ports:
- iCLK, in, 1: clock.
- iRST_N, in, 1: asynchronous, active-low reset.
- iStart, in, 1: start/restart pulse.
- iTick, in, 1: game tick, one-cycle pulse.
- iDir, in, 2: requested direction. 11 up(y-1), 00 down(y+1), 10 left(x-1), 01 right(x+1).
- iDirValid, in, 1: iDir qualifier.
- oRam_Addr, out, LW: segment RAM address.
- oRam_WData, out, XW+YW: segment data {x,y}.
- oRam_We, out, 1: RAM write enable.
- iRam_RData, in, XW+YW: synchronous read data, 1-cycle latency.
- oFood_Req, out, 1: new-food request.
- iFood_Ack, in, 1: food data valid (one cycle).
- iFood_X, in, XW: food x from generator.
- iFood_Y, in, YW: food y from generator.
- oFood_X, out, XW: placed food x.
- oFood_Y, out, YW: placed food y.
- oFood_Valid, out, 1: food placed.
- oHead_X, out, XW: current head x.
- oHead_Y, out, YW: current head y.
- oLength, out, LW: current length.
- oBusy, out, 1: update in progress.
- oGameOver, out, 1: game ended.

Behaviour:
- Reset (async, iRST_N low): all outputs 0; FSM in IDLE; direction = 10.
- States: IDLE, INIT, WAIT, SCAN, SHIFT, HEAD, FOOD, FCHK, OVER. oBusy=1 in every state except IDLE, WAIT and OVER.
- IDLE/OVER + iStart -> INIT.
  - Writes INIT_LEN segments, one per cycle: addr k gets {GRID_W/2+k, GRID_H/2}.
  - Sets head to (GRID_W/2, GRID_H/2), direction 10, length INIT_LEN.
  - Then goes to FOOD.
- Direction filter, any state:
  - iDirValid latches a pending direction unless it is the opposite of the current direction (11/00, 10/01 are opposites); opposite requests are dropped.
  - Pending is copied to current on the accepted tick.
- WAIT + iTick:
  - Compute new head: ±1 on x or y.
  - Wrap: x=0 going left -> GRID_W-1; x=GRID_W-1 going right -> 0; y wraps the same way against GRID_H.
  - eat = (new head == food) & (length < MAX_LEN). At MAX_LEN, eating is still detected for respawn but length saturates.
- SCAN:
  - Reads addr 0..last, pipelined, one address per cycle, last compare one cycle after the last read.
  - last = length-1 if eat, else length-2 (the tail vacates).
  - Any match -> OVER, oGameOver=1.
- SHIFT:
  - For i = last+1 down to 1: read i-1, then write i. Two cycles per segment.
- HEAD: write new head to addr 0 and update oHead. If eat, length+1 (saturating) and -> FOOD; else -> WAIT.
- FOOD:
  - oFood_Req=1 and oFood_Valid=0 until iFood_Ack; Req drops in the cycle after Ack.
  - Coordinates outside the grid are rejected and re-requested.
- FCHK: scans addr 0..length-1 against the candidate. Hit -> FOOD (re-request); miss -> oFood_X/Y latched, oFood_Valid=1 -> WAIT.
- iTick outside WAIT is ignored; no queuing.
- iStart outside IDLE/OVER is ignored.
- OVER holds all outputs until iStart.
- Reset asserted mid-update aborts immediately. RAM contents are undefined until the next INIT.

Optional Feature:
- Macro SNAKE_SELF_COLLIDE_EN.
- Defined: SCAN state present; self-hit ends the game.
- Undefined: SCAN removed; WAIT goes straight to SHIFT and the snake passes through itself. FCHK is still present.

Decomposition:
- Package snake_pkg: direction encodings, FSM state enum, default GRID_W/GRID_H/MAX_LEN, and a segment struct typedef {x,y}.
- Sub-module snake_dir_filter: pending/current direction registers and the reversal rejection.

Test Plan:
- Reset then iStart -> writes addr0..3 = {32,24},{33,24},{34,24},{35,24}; oLength=4; oFood_Req=1.
- Head (0,10), dir 10, iTick -> head (63,10); addr0={63,10}; addr1 = old head.
- Food at new head, length 4 -> oLength=5; old tail retained at addr4; oFood_Req=1. Ack with a body coordinate -> second request; Ack with (5,5) -> oFood_Valid=1, oFood=(5,5).
- Current dir 10, iDir=01 with iDirValid, then iTick -> still moves left. iDir=11, iTick -> moves up.
- Snake curled so new head hits segment 3 -> oGameOver=1; further iTicks have no effect; iStart -> reinitialised.
- iRST_N low during SHIFT -> all outputs 0 immediately; iStart after release -> normal INIT.
